// File: rtl/pb_cmd_sched.sv
// Push-button command scheduler: classifies presses as short/long per channel,
// keeps one pending event per button and round-robins them onto a valid/ready port.
module pb_cmd_sched #(
    parameter int N_PB     = 4,
    parameter int CNT_W    = 16,
    parameter int LONG_CYC = 50000,
    localparam int IDW     = $clog2(N_PB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_PB-1:0] prss,
    input  logic [N_PB-1:0] rls,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [IDW-1:0]  cmd_id,
    output logic            cmd_long,
    output logic [N_PB-1:0] ovf,
    input  logic            ovf_clr
);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYC - 1);

    state_t           state [N_PB];
    logic [CNT_W-1:0] cnt   [N_PB];

    logic [N_PB-1:0] pend, pend_long;
    logic [N_PB-1:0] ev, ev_long, gnt, ovf_set;
    logic [IDW-1:0]  last_grant, gnt_idx;
    logic            gnt_any, slot_free;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        return IDW'((int'(base) + off) % N_PB);
    endfunction

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        ev      = '0;
        ev_long = '0;
        for (int i = 0; i < N_PB; i++) begin
            ev[i]      = rls[i] && (state[i] != IDLE);
            ev_long[i] = (state[i] == LONG);
        end
    end

    // NOTE: the per-channel state and counter arrays are plain flops, so they are reset in a loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PB; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_PB; i++) begin
                case (state[i])
                    IDLE: begin
                        if (prss[i] && !rls[i]) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end
                    end
                    HELD: begin
                        if (rls[i])
                            state[i] <= IDLE;
                        else if (cnt[i] == LONG_M1)
                            state[i] <= LONG;
                        else
                            cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                    LONG: begin
                        if (rls[i])
                            state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign slot_free = !cmd_valid || cmd_ready;

    // First pending channel strictly after last_grant, wrapping modulo N_PB.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int off = 1; off <= N_PB; off++) begin
            if (!gnt_any && pend[rr_idx(last_grant, off)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(last_grant, off);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (slot_free && gnt_any)
            gnt[gnt_idx] = 1'b1;
        ovf_set = ev & pend & ~gnt;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            pend_long <= '0;
            ovf       <= '0;
        end else begin
            for (int i = 0; i < N_PB; i++) begin
                if (ev[i]) begin
                    if (!pend[i] || gnt[i]) begin
                        pend[i]      <= 1'b1;
                        pend_long[i] <= ev_long[i];
                    end
                end else if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            // A fresh overflow beats a simultaneous clear.
            ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            cmd_long   <= 1'b0;
            last_grant <= IDW'(N_PB - 1);
        end else if (slot_free) begin
            if (gnt_any) begin
                cmd_valid  <= 1'b1;
                cmd_id     <= gnt_idx;
                cmd_long   <= pend_long[gnt_idx];
                last_grant <= gnt_idx;
            end else begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_cmd_sched.sv
// Self-checking bench for pb_cmd_sched: scoreboard of expected commands popped
// on every handshake, plus directed timing, overflow and reset checks.
module tb_pb_cmd_sched;

    localparam int N_PB     = 4;
    localparam int CNT_W    = 16;
    localparam int LONG_CYC = 8;
    localparam int IDW      = $clog2(N_PB);

    logic            clk = 1'b0;
    logic            rst;
    logic [N_PB-1:0] prss, rls;
    logic            cmd_valid, cmd_ready, cmd_long, ovf_clr;
    logic [IDW-1:0]  cmd_id;
    logic [N_PB-1:0] ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_pushed = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           lng;
    } cmd_t;

    cmd_t exp_q[$];

    pb_cmd_sched #(.N_PB(N_PB), .CNT_W(CNT_W), .LONG_CYC(LONG_CYC)) dut (
        .clk(clk), .rst(rst), .prss(prss), .rls(rls),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_long(cmd_long), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled on falling edges.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_prss(input int ch);
        prss[ch] = 1'b1;
        tick(1);
        prss = '0;
    endtask

    task automatic pulse_rls(input int ch);
        rls[ch] = 1'b1;
        tick(1);
        rls = '0;
    endtask

    // Press, hold so the release lands k cycles after the press, then release.
    task automatic press(input int ch, input int k);
        pulse_prss(ch);
        tick(k - 1);
        pulse_rls(ch);
    endtask

    task automatic expect_cmd(input int id, input logic lng);
        exp_q.push_back('{id: IDW'(id), lng: lng});
        n_pushed++;
    endtask

    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_cmd", 32'(cmd_id), 32'hFFFF);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                check("sb_id", 32'(cmd_id), 32'(e.id));
                check("sb_long", 32'(cmd_long), 32'(e.lng));
            end
        end
    end

    initial begin
        rst = 1'b1; prss = '0; rls = '0; cmd_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_id", 32'(cmd_id), 0);
        check("rst_long", 32'(cmd_long), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        tick(2);

        // Short press on button 1: release at R, cmd_valid only at R+2.
        expect_cmd(1, 1'b0);
        press(1, 5);
        @(negedge clk) check("t1_valid_r1", 32'(cmd_valid), 0);
        @(negedge clk) check("t1_valid_r2", 32'(cmd_valid), 1);
        check("t1_id_r2", 32'(cmd_id), 1);
        check("t1_long_r2", 32'(cmd_long), 0);
        @(negedge clk) check("t1_valid_r3", 32'(cmd_valid), 0);
        tick(2);

        // Threshold: k=LONG_CYC is short, k=LONG_CYC+1 is long.
        expect_cmd(0, 1'b0);
        press(0, LONG_CYC);
        tick(4);
        expect_cmd(0, 1'b1);
        press(0, LONG_CYC + 1);
        tick(4);
        expect_cmd(2, 1'b1);
        press(2, 3 * LONG_CYC);
        tick(4);

        // Round-robin under backpressure: 0 takes the slot, then 2, 3 and 0 pend.
        cmd_ready = 1'b0;
        expect_cmd(0, 1'b0); press(0, 2); tick(2);
        expect_cmd(2, 1'b0); press(2, 2); tick(1);
        expect_cmd(3, 1'b0); press(3, 2); tick(1);
        expect_cmd(0, 1'b0); press(0, 3); tick(2);
        @(negedge clk) check("rr_hold_valid", 32'(cmd_valid), 1);
        check("rr_hold_id", 32'(cmd_id), 0);
        tick(1);
        cmd_ready = 1'b1;
        tick(8);

        // Overflow on button 2: slot + pend filled, third (long) press is dropped.
        cmd_ready = 1'b0;
        expect_cmd(2, 1'b0); press(2, 2); tick(2);
        expect_cmd(2, 1'b0); press(2, 3); tick(2);
        check("ov_pre", 32'(ovf), 0);
        press(2, LONG_CYC + 3);
        @(negedge clk) check("ov_set", 32'(ovf), 32'h4);
        check("ov_stable_id", 32'(cmd_id), 2);
        check("ov_stable_long", 32'(cmd_long), 0);
        tick(3);
        check("ov_sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ov_cleared", 32'(ovf), 0);
        // Overflow arriving with ovf_clr in the same cycle must stay set.
        pulse_prss(2);
        tick(2);
        ovf_clr = 1'b1;
        pulse_rls(2);
        ovf_clr = 1'b0;
        check("ov_beats_clr", 32'(ovf), 32'h4);
        check("ov_stable_id2", 32'(cmd_id), 2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        cmd_ready = 1'b1;
        tick(6);
        check("ov_after_drain", 32'(ovf), 0);

        // Same-cycle consume: pend[1] granted in the cycle a new button-1 event lands.
        cmd_ready = 1'b0;
        expect_cmd(1, 1'b0); press(1, 2); tick(2);
        expect_cmd(1, 1'b0); press(1, 2); tick(2);
        expect_cmd(1, 1'b1);
        pulse_prss(1);
        tick(LONG_CYC + 1);
        cmd_ready = 1'b1;
        pulse_rls(1);
        tick(6);
        check("sc_no_ovf", 32'(ovf), 0);

        // Asynchronous reset while button 3 is held and a command is presented.
        cmd_ready = 1'b0;
        press(2, 2);
        tick(3);
        pulse_prss(3);
        tick(2);
        check("rs_pre_valid", 32'(cmd_valid), 1);
        check("rs_pre_id", 32'(cmd_id), 2);
        rst = 1'b1;
        #1;
        check("rs_async_valid", 32'(cmd_valid), 0);
        check("rs_async_id", 32'(cmd_id), 0);
        check("rs_async_long", 32'(cmd_long), 0);
        check("rs_async_ovf", 32'(ovf), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        cmd_ready = 1'b1;
        pulse_rls(3);
        tick(6);
        check("rs_no_cmd", 32'(cmd_valid), 0);

        check("sb_left", 32'(exp_q.size()), 0);
        check("sb_count", 32'(n_hs), 32'(n_pushed));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
